// File: rtl/priv_csr_access_ctrl.sv
// CSR instruction sequencer: accepts one CSR access, reads the old value,
// checks privilege and read-only rules, issues one write strobe, then answers.
module priv_csr_access_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_rs1_zero,
  input  logic [1:0]  req_priv,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal,
  input  logic        retire_in,
  output logic [11:0] csr_addr,
  output logic [1:0]  curr_priv,
  output logic        csr_write,
  output logic        csr_set,
  output logic        csr_clear,
  output logic [31:0] new_csr_val,
  output logic        inst_ret,
  input  logic [31:0] old_csr_val,
  input  logic        invalid_csr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] OP_RW  = 2'b00;
  localparam logic [1:0] OP_RS  = 2'b01;
  localparam logic [1:0] OP_RC  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [1:0]  state_reg, state_next;
  logic [1:0]  op_reg;
  logic [11:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        rs1_zero_reg;
  logic [1:0]  priv_reg;
  logic [31:0] rdata_reg;
  logic        illegal_reg;
  logic        inst_ret_reg, inst_ret_next;
  logic        pending_reg, pending_next;

  logic write_intent;
  logic illegal_now;
  logic accept;
  logic csr_retire;
  logic in_write;

  // RS/RC with a zero operand is a pure read and never counts as a write.
  always_comb begin
    write_intent = (op_reg == OP_RW) ||
                   (((op_reg == OP_RS) || (op_reg == OP_RC)) && !rs1_zero_reg);
    illegal_now  = invalid_csr ||
                   (op_reg == OP_RSV) ||
                   (addr_reg[9:8] > priv_reg) ||
                   ((addr_reg[11:10] == 2'b11) && write_intent);
  end

  assign accept     = (state_reg == ST_IDLE) && req_valid;
  assign csr_retire = (state_reg == ST_RESP) && resp_ready && !illegal_reg;
  assign in_write   = (state_reg == ST_WRITE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_valid) state_next = ST_READ;
      ST_READ:  state_next = (illegal_now || !write_intent) ? ST_RESP : ST_WRITE;
      ST_WRITE: state_next = ST_RESP;
      ST_RESP:  if (resp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Pipeline retirement wins the slot; a colliding CSR retirement waits in
  // pending and goes out on the first cycle without retire_in.
  always_comb begin
    inst_ret_next = 1'b0;
    pending_next  = 1'b0;
    if (retire_in) begin
      inst_ret_next = 1'b1;
      pending_next  = pending_reg | csr_retire;
    end else if (pending_reg) begin
      inst_ret_next = 1'b1;
      pending_next  = csr_retire;
    end else begin
      inst_ret_next = csr_retire;
      pending_next  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      op_reg       <= 2'b00;
      addr_reg     <= 12'h000;
      wdata_reg    <= 32'h0;
      rs1_zero_reg <= 1'b0;
      priv_reg     <= 2'b00;
      rdata_reg    <= 32'h0;
      illegal_reg  <= 1'b0;
      inst_ret_reg <= 1'b0;
      pending_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inst_ret_reg <= inst_ret_next;
      pending_reg  <= pending_next;
      if (accept) begin
        op_reg       <= req_op;
        addr_reg     <= req_addr;
        wdata_reg    <= req_wdata;
        rs1_zero_reg <= req_rs1_zero;
        priv_reg     <= req_priv;
      end
      if (state_reg == ST_READ) begin
        rdata_reg   <= illegal_now ? 32'h0 : old_csr_val;
        illegal_reg <= illegal_now;
      end
    end
  end

  assign req_ready    = (state_reg == ST_IDLE);
  assign resp_valid   = (state_reg == ST_RESP);
  assign resp_rdata   = rdata_reg;
  assign resp_illegal = illegal_reg;
  assign csr_addr     = addr_reg;
  assign curr_priv    = priv_reg;
  assign csr_write    = in_write && (op_reg == OP_RW);
  assign csr_set      = in_write && (op_reg == OP_RS);
  assign csr_clear    = in_write && (op_reg == OP_RC);
  assign new_csr_val  = in_write ? wdata_reg : 32'h0;
  assign inst_ret     = inst_ret_reg;

endmodule

// File: tb/tb_priv_csr_access_ctrl.sv
// Bench for priv_csr_access_ctrl: directed scenarios plus randomized requests
// checked cycle by cycle against a transaction-level model.
module tb_priv_csr_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_rs1_zero;
  logic [1:0]  req_priv;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_illegal;
  logic        retire_in;
  logic [11:0] csr_addr;
  logic [1:0]  curr_priv;
  logic        csr_write, csr_set, csr_clear;
  logic [31:0] new_csr_val;
  logic        inst_ret;
  logic [31:0] old_csr_val;
  logic        invalid_csr;

  priv_csr_access_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rs1_zero(req_rs1_zero), .req_priv(req_priv),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
    .retire_in(retire_in),
    .csr_addr(csr_addr), .curr_priv(curr_priv),
    .csr_write(csr_write), .csr_set(csr_set), .csr_clear(csr_clear),
    .new_csr_val(new_csr_val), .inst_ret(inst_ret),
    .old_csr_val(old_csr_val), .invalid_csr(invalid_csr)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int owed = 0;
  int ret_count = 0;
  int retire_run = 0;
  bit rand_retire = 1'b0;
  logic [11:0] last_addr = 12'h000;
  logic [1:0]  last_priv = 2'b00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; hs means the bench expects a legal response handshake
  // in the cycle being closed. Retirements owed are modelled as a plain count.
  task automatic step(input bit hs);
    bit ret;
    bit rst_b;
    bit emit;
    int credits;
    ret   = retire_in;
    rst_b = RST;
    @(posedge CLK);
    if (rst_b) begin
      owed = 0;
      emit = 1'b0;
    end else begin
      credits = owed + (hs ? 1 : 0);
      if (ret) emit = 1'b1;
      else if (credits > 0) begin
        emit = 1'b1;
        credits--;
      end else emit = 1'b0;
      owed = credits;
    end
    #1;
    chk("inst_ret", inst_ret, emit);
    if (inst_ret === 1'b1) ret_count++;
    if (rand_retire) begin
      if (retire_in) retire_run++;
      else retire_run = 0;
      if (retire_run >= 2) retire_in = 1'b0;
      else retire_in = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic run_req(input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input bit rz, input logic [1:0] pv,
                         input logic [31:0] old, input bit inv, input int hold,
                         input bit ret_hs);
    bit wi;
    bit ill;
    logic [31:0] exp_rd;
    logic [2:0]  exp_strb;
    wi  = (op == 2'd0) || (((op == 2'd1) || (op == 2'd2)) && !rz);
    ill = inv || (op == 2'd3) || (addr[9:8] > pv) || ((addr[11:10] == 2'b11) && wi);
    exp_rd   = ill ? 32'h0 : old;
    exp_strb = (op == 2'd0) ? 3'b100 : (op == 2'd1) ? 3'b010 : 3'b001;

    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    req_rs1_zero = rz; req_priv = pv; old_csr_val = old; invalid_csr = inv;
    #1;
    chk("idle_addr_hold", csr_addr, last_addr);
    chk("idle_priv_hold", curr_priv, last_priv);
    chk("idle_resp_valid", resp_valid, 0);
    step(1'b0);

    req_valid = 1'b0; req_op = 2'($urandom); req_addr = 12'($urandom);
    req_wdata = $urandom; req_rs1_zero = 1'($urandom); req_priv = 2'($urandom);
    last_addr = addr; last_priv = pv;
    #1;
    chk("read_ready", req_ready, 0);
    chk("read_resp_valid", resp_valid, 0);
    chk("read_strobes", {csr_write, csr_set, csr_clear}, 0);
    chk("read_new_val", new_csr_val, 0);
    chk("read_addr", csr_addr, addr);
    chk("read_priv", curr_priv, pv);
    step(1'b0);
    old_csr_val = $urandom;
    invalid_csr = 1'($urandom);
    #1;

    if (wi && !ill) begin
      chk("write_strobes", {csr_write, csr_set, csr_clear}, exp_strb);
      chk("write_new_val", new_csr_val, wd);
      chk("write_addr", csr_addr, addr);
      chk("write_resp_valid", resp_valid, 0);
      step(1'b0);
    end

    for (int h = 0; h < hold; h++) begin
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_illegal", resp_illegal, ill);
      chk("hold_strobes", {csr_write, csr_set, csr_clear}, 0);
      chk("hold_new_val", new_csr_val, 0);
      chk("hold_ready", req_ready, 0);
      step(1'b0);
    end

    resp_ready = 1'b1;
    chk("resp_valid", resp_valid, 1);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_illegal", resp_illegal, ill);
    chk("resp_strobes", {csr_write, csr_set, csr_clear}, 0);
    chk("resp_addr", csr_addr, addr);
    if (ret_hs) retire_in = 1'b1;
    step(!ill);
    resp_ready = 1'b0;
    chk("post_ready", req_ready, 1);
    chk("post_resp_valid", resp_valid, 0);
    $display("req op=%0d addr=%03h priv=%0d rz=%0b inv=%0b -> illegal=%0b rdata=%08h",
             op, addr, pv, rz, inv, ill, exp_rd);
  endtask

  initial begin
    int c0;
    RST = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 12'h000;
    req_wdata = 32'h0; req_rs1_zero = 1'b0; req_priv = 2'b00;
    resp_ready = 1'b0; retire_in = 1'b0; old_csr_val = 32'h0; invalid_csr = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_illegal", resp_illegal, 0);
    chk("rst_csr_addr", csr_addr, 0);
    chk("rst_curr_priv", curr_priv, 0);
    chk("rst_strobes", {csr_write, csr_set, csr_clear}, 0);
    chk("rst_new_val", new_csr_val, 0);
    RST = 1'b0;
    step(1'b0);

    c0 = ret_count;
    run_req(2'd0, 12'h340, 32'hDEADBEEF, 1'b0, 2'd3, 32'h12345678, 1'b0, 0, 1'b0);
    step(1'b0);
    step(1'b0);
    chk("rw_ret_count", ret_count - c0, 1);

    run_req(2'd1, 12'h300, 32'h000000FF, 1'b1, 2'd3, 32'hA5A50001, 1'b0, 5, 1'b0);

    c0 = ret_count;
    run_req(2'd0, 12'hC00, 32'h11111111, 1'b0, 2'd3, 32'h77777777, 1'b0, 1, 1'b0);
    step(1'b0);
    chk("ro_ret_count", ret_count - c0, 0);
    run_req(2'd1, 12'hC00, 32'h0, 1'b1, 2'd3, 32'h00C0FFEE, 1'b0, 0, 1'b0);

    run_req(2'd2, 12'h300, 32'h0000000F, 1'b0, 2'd0, 32'h22222222, 1'b0, 0, 1'b0);
    run_req(2'd0, 12'h300, 32'h33333333, 1'b0, 2'd3, 32'h44444444, 1'b1, 0, 1'b0);
    run_req(2'd3, 12'h340, 32'h55555555, 1'b0, 2'd3, 32'h66666666, 1'b0, 0, 1'b0);
    run_req(2'd2, 12'h341, 32'h0000F00F, 1'b0, 2'd3, 32'h0BADF00D, 1'b0, 0, 1'b0);
    run_req(2'd1, 12'h100, 32'h00000002, 1'b0, 2'd1, 32'h00000001, 1'b0, 2, 1'b0);

    c0 = ret_count;
    run_req(2'd0, 12'h340, 32'h01234567, 1'b0, 2'd3, 32'h89ABCDEF, 1'b0, 0, 1'b1);
    retire_in = 1'b1;
    step(1'b0);
    retire_in = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("coincide_ret_count", ret_count - c0, 3);

    // Reset while the write strobe is up must abort the whole request.
    c0 = ret_count;
    req_valid = 1'b1; req_op = 2'd0; req_addr = 12'h340; req_wdata = 32'hCAFEF00D;
    req_rs1_zero = 1'b0; req_priv = 2'd3; old_csr_val = 32'h13579BDF; invalid_csr = 1'b0;
    step(1'b0);
    req_valid = 1'b0;
    step(1'b0);
    chk("abort_write_strobe", csr_write, 1);
    RST = 1'b1;
    step(1'b0);
    RST = 1'b0;
    last_addr = 12'h000; last_priv = 2'b00;
    resp_ready = 1'b1;
    chk("abort_strobes", {csr_write, csr_set, csr_clear}, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_csr_addr", csr_addr, 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_resp_valid", resp_valid, 0);
      step(1'b0);
    end
    resp_ready = 1'b0;
    chk("abort_ret_count", ret_count - c0, 0);

    rand_retire = 1'b1;
    for (int n = 0; n < 250; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        chk("gap_ready", req_ready, 1);
        chk("gap_resp_valid", resp_valid, 0);
        step(1'b0);
      end
      run_req(2'($urandom_range(0, 3)), 12'($urandom), $urandom,
              ($urandom_range(0, 3) == 0), 2'($urandom), $urandom,
              ($urandom_range(0, 7) == 0), $urandom_range(0, 3), 1'b0);
    end
    rand_retire = 1'b0;
    retire_in = 1'b0;
    repeat (4) step(1'b0);
    chk("drain_owed", owed, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
